spell_mem_loader: RTL and testbench
===================================

# spell_mem_loader

Serial loader that lets an external host write and read back the Spell memories over a 4-wire SPI-style port, acting as a bus master on the memory request interface (`select`/`addr`/`data_in`/`memory_type_data`/`write` → `data_out`/`data_ready`). It sits directly upstream of the internal memory, or of the mux in front of it, and is used to program code memory and inspect data memory while the CPU is halted. Host bytes are decoded into command, address and data phases; every data byte becomes exactly one memory access, with the address auto-incrementing.

## Interface
- No parameters.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `sclk`  in  1  host serial clock, asynchronous to `clk`.
- `cs_n`  in  1  host chip-select, active-low, asynchronous.
- `sdi`  in  1  host serial data in, MSB first.
- `sdo`  out  1  serial data out, MSB first.
- `select`  out  1  memory request; held until `data_ready` is seen.
- `addr`  out  8  memory address.
- `data_in`  out  8  write data.
- `memory_type_data`  out  1  1 = data memory, 0 = code memory.
- `write`  out  1  1 = write, 0 = read.
- `data_out`  in  8  memory read data; valid when `data_ready`=1.
- `data_ready`  in  1  memory completion; registered, cleared by the memory while `select`=0.
- `busy`  out  1  high while `cs_n` is low or a memory access is outstanding.

## Operation
- Synchronization:
  - `sclk`, `cs_n` and `sdi` each pass through a 2-FF synchronizer.
  - sclk rising and falling edges are detected in the `clk` domain.
  - Requirement: `clk` ≥ 16× `sclk`.
- SPI mode 0:
  - `sdi` is sampled on sclk rise.
  - `sdo` changes on sclk fall.
  - A bit counter (3 bits) counts 8 rises per byte.
- Transaction phases, in the order received after `cs_n` falls:
  - byte 0 (CMD): bit7 = write, bit6 = memory_type_data, bits5:0 ignored.
  - byte 1 (ADDR): start address.
  - bytes 2.. (DATA): one memory access per byte.
- Write (CMD bit7 = 1):
  - On the 8th rise of each DATA byte, a write of that byte is issued at the current address.
  - The address then increments.
- Read (CMD bit7 = 0):
  - On completion of the ADDR byte, a read of `addr` is issued (prefetch).
  - On the first sclk fall of each DATA byte, the prefetched byte is loaded into the output shift register, the address increments, and the next read is issued.
  - `sdo` = 0 during the CMD and ADDR bytes.
- Address arithmetic: 8-bit, wraps 0xFF → 0x00.
- `memory_type_data` and `write` are latched from CMD for the whole transaction.
- Memory FSM, states MIDLE → MREQ → MGAP → MIDLE:
  - MIDLE: on a request, drive addr/data_in/write/type, assert `select`, go to MREQ.
  - MREQ: hold all outputs stable until `data_ready`=1. On a read, capture `data_out` into the prefetch register. Deassert `select`, go to MGAP.
  - MGAP: one cycle with `select`=0, then MIDLE.
- Protocol FSM, states IDLE, CMD, ADDR, DATA:
  - `cs_n` fall → CMD; byte complete → ADDR → DATA; DATA stays in DATA.
  - `cs_n` rise in any state → IDLE.
  - A partial byte is discarded with no memory access.
  - An in-flight memory access still completes through MGAP.
- A new request arriving while the memory FSM is not in MIDLE is queued (single-entry pending flag). It cannot overflow given the clock ratio.
- Reset values: `select`=0, `write`=0, `memory_type_data`=0, `addr`=0x00, `data_in`=0x00, `sdo`=0, `busy`=0. Both FSMs go to idle.
- Reset mid-operation: everything is cleared immediately, including `select`.

## Timing
- Write: `select` rises 1 `clk` after the synchronized 8th sclk rise. It stays high for (memory latency + 1) cycles; memory latency is 1 cycle, or 4 cycles in the delayed-memory build.
- Read prefetch completes within 8 `clk` cycles. The data is ready before the next byte's first sclk fall.
- `busy` falls 1 cycle after both FSMs are idle.
- Pin-to-action latency: 3 `clk` cycles (2 sync stages plus edge detect).

## Structure
- Package `spell_loader_pkg`:
  - CMD bit positions `CMD_WRITE_BIT`=7 and `CMD_TYPE_BIT`=6.
  - Protocol FSM state type.
  - Memory FSM state type.
- Sub-module `spell_sync2`: 2-FF synchronizer, instanced three times.

## Test plan
- Code write then read:
  - Write: cmd 0x80, addr 0x10, data 0xAA 0x55 0x01 → three writes with `memory_type_data`=0 at 0x10, 0x11, 0x12.
  - Read: cmd 0x00, addr 0x10, 3 dummy bytes → `sdo` shifts 0xAA 0x55 0x01.
- Data memory: cmd 0xC0, addr 0x1F, data 0x5A 0x77 → write at 0x1F, then write at 0x20, which is dropped by the memory. Read via 0x40 returns 0x5A, 0x00.
- Wrap: cmd 0x80, addr 0xFF, data 0x11 0x22 → writes at 0xFF, then 0x00.
- Abort: `cs_n` rises after 5 bits of a DATA byte → no `select` pulse for that byte; `busy` falls; the next transaction works normally.
- Delayed memory (4-cycle `data_ready`): same as the first scenario; `select` is held until `data_ready`, and all values match.
- Reset mid-write: `rst_n`=0 while `select`=1 → next cycle `select`=0, `addr`=0x00, `busy`=0.

Source files
------------

// File: rtl/spell_loader_pkg.sv
// ============================================================================
//  Module      : spell_loader_pkg
//  Description : Shared constants and FSM state types for the Spell memory
//                serial loader.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package spell_loader_pkg;

  // Bit positions inside the command byte
  localparam int CMD_WRITE_BIT = 7;
  localparam int CMD_TYPE_BIT  = 6;

  // Host protocol phase
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    ADDR = 2'd2,
    DATA = 2'd3
  } proto_state_t;

  // Memory bus master state
  typedef enum logic [1:0] {
    MIDLE = 2'd0,
    MREQ  = 2'd1,
    MGAP  = 2'd2
  } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/spell_sync2.sv
// ============================================================================
//  Module      : spell_sync2
//  Description : Two-flop synchronizer for a single asynchronous input bit.
//                RST_VAL selects the idle level held during reset.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module spell_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops to settle metastability before use in clk domain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/spell_mem_loader.sv
// ============================================================================
//  Module      : spell_mem_loader
//  Description : SPI mode-0 slave that decodes CMD / ADDR / DATA bytes from a
//                host and turns each DATA byte into one access on the Spell
//                memory request bus (select/addr/data_in/write/type), with
//                auto-incrementing address and read prefetch for sdo.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module spell_mem_loader
  import spell_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       sdi,
  output logic       sdo,
  output logic       select,
  output logic [7:0] addr,
  output logic [7:0] data_in,
  output logic       memory_type_data,
  output logic       write,
  input  logic [7:0] data_out,
  input  logic       data_ready,
  output logic       busy
);

  // --------------------------------------------------------------------------
  // Host pin synchronization and sclk edge detection
  // --------------------------------------------------------------------------
  logic w_sclk_s;
  logic w_cs_n_s;
  logic w_sdi_s;
  logic r_sclk_d;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_active;

  spell_sync2 #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sclk),
    .q     (w_sclk_s)
  );

  // chip select idles high so reset must not look like a selection
  spell_sync2 #(.RST_VAL(1'b1)) u_sync_cs_n (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cs_n),
    .q     (w_cs_n_s)
  );

  spell_sync2 #(.RST_VAL(1'b0)) u_sync_sdi (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sdi),
    .q     (w_sdi_s)
  );

  // Delayed copy of synchronized sclk for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) r_sclk_d <= 1'b0;
    else        r_sclk_d <= w_sclk_s;
  end

  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_cs_active = ~w_cs_n_s;

  // --------------------------------------------------------------------------
  // Protocol state and serial datapath
  // --------------------------------------------------------------------------
  proto_state_t r_pstate;
  proto_state_t w_pstate_nxt;

  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift_in;
  logic [7:0] r_sdo_sr;
  logic [7:0] r_addr_ptr;
  logic       r_cmd_write;
  logic       r_cmd_type;
  logic [7:0] r_prefetch;

  logic       w_in_txn;
  logic [7:0] w_byte;
  logic       w_byte_done;
  logic       w_load_fall;

  // Memory request produced by the protocol side this cycle
  logic       w_req;
  logic [7:0] w_req_addr;
  logic [7:0] w_req_data;

  assign w_in_txn    = (r_pstate != IDLE) && w_cs_active;
  assign w_byte      = {r_shift_in, w_sdi_s};
  assign w_byte_done = w_in_txn && w_sclk_rise && (r_bit_cnt == 3'd7);
  // First fall of a read DATA byte: hand over prefetched byte to the shifter.
  // It follows the last rise of the previous byte, so bit7 is on sdo before
  // the host samples the first bit.
  assign w_load_fall = w_in_txn && (r_pstate == DATA) && w_sclk_fall &&
                       (r_bit_cnt == 3'd0) && !r_cmd_write;

  // Protocol state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_pstate <= IDLE;
    else        r_pstate <= w_pstate_nxt;
  end

  // Protocol next state and memory request generation
  always_comb begin
    w_pstate_nxt = r_pstate;
    w_req        = 1'b0;
    w_req_addr   = r_addr_ptr;
    w_req_data   = w_byte;

    if (!w_cs_active) begin
      w_pstate_nxt = IDLE;
    end else begin
      case (r_pstate)
        IDLE:    w_pstate_nxt = CMD;
        CMD:     if (w_byte_done) w_pstate_nxt = ADDR;
        ADDR:    if (w_byte_done) w_pstate_nxt = DATA;
        DATA:    w_pstate_nxt = DATA;
        default: w_pstate_nxt = IDLE;
      endcase
    end

    // Read: prefetch the start address as soon as it is known
    if ((r_pstate == ADDR) && w_byte_done && !r_cmd_write) begin
      w_req      = 1'b1;
      w_req_addr = w_byte;
    end
    // Write: every completed data byte goes to the current address
    if ((r_pstate == DATA) && w_byte_done && r_cmd_write) begin
      w_req      = 1'b1;
      w_req_addr = r_addr_ptr;
    end
    // Read: the byte just consumed frees the prefetch for the next address
    if (w_load_fall) begin
      w_req      = 1'b1;
      w_req_addr = r_addr_ptr + 8'd1;
    end
  end

  // Bit counting, shifting, command latching and address pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit_cnt   <= 3'd0;
      r_shift_in  <= 7'd0;
      r_sdo_sr    <= 8'd0;
      r_addr_ptr  <= 8'd0;
      r_cmd_write <= 1'b0;
      r_cmd_type  <= 1'b0;
    end else begin
      // New selection: drop any partial byte left from an aborted transfer
      if ((r_pstate == IDLE) && w_cs_active) begin
        r_bit_cnt <= 3'd0;
        r_sdo_sr  <= 8'd0;
      end
      if (!w_cs_active) begin
        r_sdo_sr <= 8'd0;
      end
      if (w_in_txn && w_sclk_rise) begin
        r_shift_in <= w_byte[6:0];
        r_bit_cnt  <= r_bit_cnt + 3'd1;
      end
      if (w_in_txn && w_sclk_fall) begin
        if (w_load_fall) r_sdo_sr <= r_prefetch;
        else             r_sdo_sr <= {r_sdo_sr[6:0], 1'b0};
      end
      if ((r_pstate == CMD) && w_byte_done) begin
        r_cmd_write <= w_byte[CMD_WRITE_BIT];
        r_cmd_type  <= w_byte[CMD_TYPE_BIT];
      end
      if ((r_pstate == ADDR) && w_byte_done) begin
        r_addr_ptr <= w_byte;
      end
      if (((r_pstate == DATA) && w_byte_done && r_cmd_write) || w_load_fall) begin
        r_addr_ptr <= r_addr_ptr + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Memory bus master with single-entry pending slot
  // --------------------------------------------------------------------------
  mem_state_t r_mstate;
  mem_state_t w_mstate_nxt;

  logic       r_select;
  logic [7:0] r_addr;
  logic [7:0] r_data_in;
  logic       r_pend_valid;
  logic [7:0] r_pend_addr;
  logic [7:0] r_pend_data;
  logic       r_busy;

  logic       w_select_nxt;
  logic [7:0] w_addr_nxt;
  logic [7:0] w_data_in_nxt;
  logic [7:0] w_prefetch_nxt;
  logic       w_pend_valid_nxt;
  logic [7:0] w_pend_addr_nxt;
  logic [7:0] w_pend_data_nxt;

  // Memory state and bus output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mstate     <= MIDLE;
      r_select     <= 1'b0;
      r_addr       <= 8'd0;
      r_data_in    <= 8'd0;
      r_prefetch   <= 8'd0;
      r_pend_valid <= 1'b0;
      r_pend_addr  <= 8'd0;
      r_pend_data  <= 8'd0;
    end else begin
      r_mstate     <= w_mstate_nxt;
      r_select     <= w_select_nxt;
      r_addr       <= w_addr_nxt;
      r_data_in    <= w_data_in_nxt;
      r_prefetch   <= w_prefetch_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_addr  <= w_pend_addr_nxt;
      r_pend_data  <= w_pend_data_nxt;
    end
  end

  // Memory next state: issue, wait for data_ready, one idle gap
  always_comb begin
    w_mstate_nxt     = r_mstate;
    w_select_nxt     = r_select;
    w_addr_nxt       = r_addr;
    w_data_in_nxt    = r_data_in;
    w_prefetch_nxt   = r_prefetch;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_addr_nxt  = r_pend_addr;
    w_pend_data_nxt  = r_pend_data;

    case (r_mstate)
      MIDLE: begin
        // A queued request is older, so it goes first
        if (r_pend_valid) begin
          w_select_nxt     = 1'b1;
          w_addr_nxt       = r_pend_addr;
          w_data_in_nxt    = r_pend_data;
          w_pend_valid_nxt = 1'b0;
          w_mstate_nxt     = MREQ;
        end else if (w_req) begin
          w_select_nxt  = 1'b1;
          w_addr_nxt    = w_req_addr;
          w_data_in_nxt = w_req_data;
          w_mstate_nxt  = MREQ;
        end
      end
      MREQ: begin
        if (data_ready) begin
          if (!r_cmd_write) w_prefetch_nxt = data_out;
          w_select_nxt = 1'b0;
          w_mstate_nxt = MGAP;
        end
      end
      MGAP: begin
        // Lets the memory see select low and clear data_ready
        w_mstate_nxt = MIDLE;
      end
      default: begin
        w_select_nxt = 1'b0;
        w_mstate_nxt = MIDLE;
      end
    endcase

    // Park a request that could not be issued directly
    if (w_req && !((r_mstate == MIDLE) && !r_pend_valid)) begin
      w_pend_valid_nxt = 1'b1;
      w_pend_addr_nxt  = w_req_addr;
      w_pend_data_nxt  = w_req_data;
    end
  end

  // Busy flag: host selected or memory work still outstanding
  always_ff @(posedge clk) begin
    if (!rst_n) r_busy <= 1'b0;
    else        r_busy <= w_cs_active || (r_pstate != IDLE) ||
                          (r_mstate != MIDLE) || r_pend_valid;
  end

  assign sdo              = r_sdo_sr[7];
  assign select           = r_select;
  assign addr             = r_addr;
  assign data_in          = r_data_in;
  assign memory_type_data = r_cmd_type;
  assign write            = r_cmd_write;
  assign busy             = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_spell_mem_loader.sv
// ============================================================================
//  Module      : tb_spell_mem_loader
//  Description : Directed self-checking bench for spell_mem_loader with a
//                behavioural memory (code 256 B, data 32 B, variable latency).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spell_mem_loader;

  localparam int HALF = 100;  // sclk half period in ns (20 clk per sclk)

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       sdi = 1'b0;
  logic       sdo;
  logic       select;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic       memory_type_data;
  logic       write;
  logic [7:0] data_out = 8'h00;
  logic       data_ready = 1'b0;
  logic       busy;

  int checks = 0;
  int failures = 0;

  spell_mem_loader dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sclk             (sclk),
    .cs_n             (cs_n),
    .sdi              (sdi),
    .sdo              (sdo),
    .select           (select),
    .addr             (addr),
    .data_in          (data_in),
    .memory_type_data (memory_type_data),
    .write            (write),
    .data_out         (data_out),
    .data_ready       (data_ready),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Behavioural memory: data memory only decodes 0x00-0x1F
  logic [7:0] code_mem [256];
  logic [7:0] data_mem [32];
  int         mem_lat = 1;
  int         lat_cnt = 0;
  logic       mem_clear = 1'b0;
  logic [7:0] wr_addr_log [64];
  logic [7:0] wr_data_log [64];
  logic       wr_type_log [64];
  int         wr_cnt = 0;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) code_mem[i] <= 8'h00;
      for (int i = 0; i < 32; i++)  data_mem[i] <= 8'h00;
    end
    if (!select) begin
      data_ready <= 1'b0;
      lat_cnt    <= 0;
    end else if (!data_ready) begin
      if (lat_cnt + 1 >= mem_lat) begin
        data_ready <= 1'b1;
        lat_cnt    <= 0;
        if (write) begin
          wr_addr_log[wr_cnt % 64] <= addr;
          wr_data_log[wr_cnt % 64] <= data_in;
          wr_type_log[wr_cnt % 64] <= memory_type_data;
          wr_cnt <= wr_cnt + 1;
          if (memory_type_data) begin
            if (addr < 8'h20) data_mem[addr[4:0]] <= data_in;
          end else begin
            code_mem[addr] <= data_in;
          end
        end else begin
          if (memory_type_data) data_out <= (addr < 8'h20) ? data_mem[addr[4:0]] : 8'h00;
          else                  data_out <= code_mem[addr];
        end
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end
  end

  // Select pulse monitor: number of pulses and length of the last one
  int   sel_pulses = 0;
  int   sel_run = 0;
  int   sel_len_last = 0;
  logic sel_prev = 1'b0;

  always @(negedge clk) begin
    if (select && !sel_prev) sel_pulses = sel_pulses + 1;
    if (select) begin
      sel_run = sel_run + 1;
    end else begin
      if (sel_prev) sel_len_last = sel_run;
      sel_run = 0;
    end
    sel_prev = select;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      sdi = tx[7-i];
      #(HALF);
      sclk = 1'b1;
      rx[7-i] = sdo;
      #(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] tx, output logic [7:0] rx);
    send_bits(tx, 8, rx);
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    #(HALF);
  endtask

  task automatic cs_end();
    #(HALF);
    cs_n = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    int         base;
    int         p0;

    mem_clear = 1'b1;
    rst_n     = 1'b0;
    repeat (5) @(negedge clk);
    mem_clear = 1'b0;

    // Reset values
    chk("rst_select", select, 1'b0);
    chk("rst_write", write, 1'b0);
    chk("rst_type", memory_type_data, 1'b0);
    chk("rst_addr", addr, 8'h00);
    chk("rst_data_in", data_in, 8'h00);
    chk("rst_sdo", sdo, 1'b0);
    chk("rst_busy", busy, 1'b0);

    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Code write: 0x80 0x10 AA 55 01
    base = wr_cnt;
    cs_begin();
    send_byte(8'h80, rx);
    send_byte(8'h10, rx);
    chk("wr_busy_active", busy, 1'b1);
    send_byte(8'hAA, rx);
    send_byte(8'h55, rx);
    send_byte(8'h01, rx);
    cs_end();
    chk("wr_count", wr_cnt - base, 3);
    chk("wr0_addr", wr_addr_log[base], 8'h10);
    chk("wr0_data", wr_data_log[base], 8'hAA);
    chk("wr0_type", wr_type_log[base], 1'b0);
    chk("wr1_addr", wr_addr_log[base+1], 8'h11);
    chk("wr1_data", wr_data_log[base+1], 8'h55);
    chk("wr2_addr", wr_addr_log[base+2], 8'h12);
    chk("wr2_data", wr_data_log[base+2], 8'h01);
    chk("wr2_type", wr_type_log[base+2], 1'b0);
    chk("wr_busy_idle", busy, 1'b0);
    chk("wr_sel_len", sel_len_last, 2);

    // Code read back: 0x00 0x10 + 3 dummies
    cs_begin();
    send_byte(8'h00, rx);
    chk("rd_sdo_cmd", rx, 8'h00);
    send_byte(8'h10, rx);
    chk("rd_sdo_addr", rx, 8'h00);
    send_byte(8'h00, rx);
    chk("rd_byte0", rx, 8'hAA);
    send_byte(8'h00, rx);
    chk("rd_byte1", rx, 8'h55);
    send_byte(8'h00, rx);
    chk("rd_byte2", rx, 8'h01);
    cs_end();
    chk("rd_busy_idle", busy, 1'b0);

    // Data memory: 0xC0 0x1F 5A 77, second write lands beyond the array
    base = wr_cnt;
    cs_begin();
    send_byte(8'hC0, rx);
    send_byte(8'h1F, rx);
    send_byte(8'h5A, rx);
    send_byte(8'h77, rx);
    cs_end();
    chk("dm_count", wr_cnt - base, 2);
    chk("dm0_addr", wr_addr_log[base], 8'h1F);
    chk("dm0_type", wr_type_log[base], 1'b1);
    chk("dm1_addr", wr_addr_log[base+1], 8'h20);
    chk("dm1_data", wr_data_log[base+1], 8'h77);
    cs_begin();
    send_byte(8'h40, rx);
    send_byte(8'h1F, rx);
    send_byte(8'h00, rx);
    chk("dm_rd0", rx, 8'h5A);
    send_byte(8'h00, rx);
    chk("dm_rd1", rx, 8'h00);
    cs_end();

    // Address wrap: 0x80 0xFF 11 22
    base = wr_cnt;
    cs_begin();
    send_byte(8'h80, rx);
    send_byte(8'hFF, rx);
    send_byte(8'h11, rx);
    send_byte(8'h22, rx);
    cs_end();
    chk("wrap0_addr", wr_addr_log[base], 8'hFF);
    chk("wrap0_data", wr_data_log[base], 8'h11);
    chk("wrap1_addr", wr_addr_log[base+1], 8'h00);
    chk("wrap1_data", wr_data_log[base+1], 8'h22);

    // Abort after 5 bits of the first data byte
    p0 = sel_pulses;
    cs_begin();
    send_byte(8'h80, rx);
    send_byte(8'h30, rx);
    send_bits(8'hF0, 5, rx);
    cs_end();
    chk("abort_no_select", sel_pulses - p0, 0);
    chk("abort_busy_idle", busy, 1'b0);
    base = wr_cnt;
    cs_begin();
    send_byte(8'h80, rx);
    send_byte(8'h31, rx);
    send_byte(8'h3C, rx);
    cs_end();
    chk("post_abort_count", wr_cnt - base, 1);
    chk("post_abort_addr", wr_addr_log[base], 8'h31);
    chk("post_abort_data", wr_data_log[base], 8'h3C);

    // Delayed memory: repeat the first scenario on a cleared memory
    mem_lat   = 4;
    mem_clear = 1'b1;
    @(negedge clk);
    mem_clear = 1'b0;
    base = wr_cnt;
    cs_begin();
    send_byte(8'h80, rx);
    send_byte(8'h10, rx);
    send_byte(8'hAA, rx);
    send_byte(8'h55, rx);
    send_byte(8'h01, rx);
    cs_end();
    chk("dly_count", wr_cnt - base, 3);
    chk("dly0_addr", wr_addr_log[base], 8'h10);
    chk("dly1_data", wr_data_log[base+1], 8'h55);
    chk("dly2_addr", wr_addr_log[base+2], 8'h12);
    chk("dly_sel_len", sel_len_last, 5);
    cs_begin();
    send_byte(8'h00, rx);
    send_byte(8'h10, rx);
    send_byte(8'h00, rx);
    chk("dly_rd0", rx, 8'hAA);
    send_byte(8'h00, rx);
    chk("dly_rd1", rx, 8'h55);
    send_byte(8'h00, rx);
    chk("dly_rd2", rx, 8'h01);
    cs_end();

    // Reset asserted while a write is on the bus
    mem_lat = 4;
    cs_begin();
    send_byte(8'h80, rx);
    send_byte(8'h50, rx);
    send_bits(8'hEE, 7, rx);
    sdi = 1'b0;
    #(HALF);
    sclk = 1'b1;
    for (int n = 0; n < 50 && !select; n++) @(negedge clk);
    chk("rst_mid_sel_seen", select, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_select", select, 1'b0);
    chk("rst_mid_addr", addr, 8'h00);
    chk("rst_mid_busy", busy, 1'b0);
    sclk = 1'b0;
    cs_n = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
